// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// and MEM-stage loads/stores, with round-robin tie breaking.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_u_b_h_w,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_u_b_h_w,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [3:0] cnt;
  logic       gnt_any;
  logic       gnt_d;

  // Ties go to whichever side was not served last.
  always_comb begin
    gnt_d = 1'b0;
    unique case (1'b1)
      d_req && !if_req: gnt_d = 1'b1;
      if_req && !d_req: gnt_d = 1'b0;
      default:          gnt_d = (last_grant == OWN_IF);
    endcase
  end

  assign gnt_any = (state == S_IDLE) && (if_req || d_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      last_grant  <= OWN_IF;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_u_b_h_w <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            state      <= S_BUSY;
            owner      <= gnt_d;
            last_grant <= gnt_d;
            cnt        <= LAT;
            mem_en     <= 1'b1;
            if (gnt_d) begin
              mem_we      <= d_we;
              mem_addr    <= d_addr;
              mem_wdata   <= d_wdata;
              mem_u_b_h_w <= d_u_b_h_w;
            end else begin
              mem_we      <= 1'b0;
              mem_addr    <= if_addr;
              mem_u_b_h_w <= 3'b010;
            end
          end
        end
        S_BUSY: begin
          mem_en <= 1'b0;
          if (cnt == 4'd1) begin
            state <= S_DONE;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          mem_we   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;
  assign busy      = (state != S_IDLE);

endmodule
